// File: rtl/dsp_mem_deframer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_mem_deframer_pkg
//  Description : Shared FSM state encoding and default sizing constants for
//                the memory-readout deframer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_mem_deframer_pkg;

    localparam int c_FRAME_LENGTH = 64;
    localparam int c_WORD_WIDTH   = 32;
    localparam int c_COUNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dsp_mem_deframer_sync_det.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_mem_deframer_sync_det
//  Description : Serial shift register and syncword comparator; the match
//                includes the bit being shifted in this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_mem_deframer_sync_det
    import dsp_mem_deframer_pkg::*;
#(
    parameter int FrameLength = c_FRAME_LENGTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_shift,
    input  logic                   i_bit,
    input  logic [FrameLength-1:0] i_syncword,
    output logic                   o_match,
    output logic                   o_last
);

    localparam int c_FILL_W = $clog2(FrameLength + 1);

    // Only the FrameLength-1 most recent bits are stored; the live bit
    // completes the FrameLength-bit window.
    logic [FrameLength-2:0] r_hist;
    logic [c_FILL_W-1:0]    r_fill;
    logic [FrameLength-1:0] w_window;
    logic                   w_full_now;

    assign w_window   = {r_hist, i_bit};
    assign w_full_now = (r_fill >= c_FILL_W'(FrameLength - 1));
    assign o_match    = i_shift && w_full_now && (w_window == i_syncword);
    assign o_last     = i_shift && (r_fill == c_FILL_W'(FrameLength - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_window[FrameLength-2:0];
            if (r_fill != c_FILL_W'(FrameLength)) begin
                r_fill <= r_fill + c_FILL_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsp_mem_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_mem_deframer
//  Description : Hunts a syncword in a serial memory readout, assembles the
//                payload into words and optionally verifies the postamble.
//                Postamble check built only with DSP_MEM_DEFRAMER_POSTCHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_mem_deframer
    import dsp_mem_deframer_pkg::*;
#(
    parameter int FrameLength = c_FRAME_LENGTH,
    parameter int WordWidth   = c_WORD_WIDTH,
    parameter int CountWidth  = c_COUNT_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_bit,
    input  logic                   i_bit_vld,
    input  logic                   i_start,
    input  logic [FrameLength-1:0] i_cfg_syncword,
    input  logic [CountWidth-1:0]  i_cfg_payload_words,
    input  logic [CountWidth-1:0]  i_cfg_hunt_max,
    output logic [WordWidth-1:0]   o_word,
    output logic                   o_word_vld,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err_hunt,
    output logic                   o_err_post
);

    localparam int c_BIT_W = $clog2(WordWidth);

`ifdef DSP_MEM_DEFRAMER_POSTCHK_EN
    localparam state_t c_AFTER_PAYLOAD = ST_CHECK;
    localparam logic   c_AFTER_DONE    = 1'b0;
`else
    localparam state_t c_AFTER_PAYLOAD = ST_DONE;
    localparam logic   c_AFTER_DONE    = 1'b1;
`endif

    state_t                 r_state;
    logic [FrameLength-1:0] r_cfg_sync;
    logic [CountWidth-1:0]  r_cfg_words;
    logic [CountWidth-1:0]  r_cfg_hunt_max;
    logic [CountWidth-1:0]  r_hunt_cnt;
    logic [CountWidth-1:0]  r_word_cnt;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [WordWidth-2:0]   r_word_sr;
    logic [WordWidth-1:0]   r_word;
    logic                   r_word_vld;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err_hunt;
`ifdef DSP_MEM_DEFRAMER_POSTCHK_EN
    logic                   r_err_post;
`endif

    logic                   w_det_shift;
    logic                   w_det_clr;
    logic                   w_match;
    logic                   w_last;
    logic [CountWidth-1:0]  w_hunt_cnt_inc;
    logic [CountWidth-1:0]  w_word_cnt_inc;
    logic [WordWidth-1:0]   w_word_full;

    assign w_det_shift    = i_bit_vld && ((r_state == ST_HUNT) || (r_state == ST_CHECK));
    // Detector is held empty outside HUNT/CHECK so CHECK needs a fresh full window.
    assign w_det_clr      = !((r_state == ST_HUNT) || (r_state == ST_CHECK))
                            || ((r_state == ST_HUNT) && w_match);
    assign w_hunt_cnt_inc = (r_hunt_cnt == '1) ? r_hunt_cnt : r_hunt_cnt + CountWidth'(1);
    assign w_word_cnt_inc = (r_word_cnt == '1) ? r_word_cnt : r_word_cnt + CountWidth'(1);
    assign w_word_full    = {r_word_sr, i_bit};

    dsp_mem_deframer_sync_det #(
        .FrameLength (FrameLength)
    ) u_sync_det (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_det_clr),
        .i_shift    (w_det_shift),
        .i_bit      (i_bit),
        .i_syncword (r_cfg_sync),
        .o_match    (w_match),
        .o_last     (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_cfg_sync     <= '0;
            r_cfg_words    <= '0;
            r_cfg_hunt_max <= '0;
            r_hunt_cnt     <= '0;
            r_word_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_word_sr      <= '0;
            r_word         <= '0;
            r_word_vld     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_hunt     <= 1'b0;
`ifdef DSP_MEM_DEFRAMER_POSTCHK_EN
            r_err_post     <= 1'b0;
`endif
        end else begin
            r_word_vld <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state        <= ST_HUNT;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_err_hunt     <= 1'b0;
`ifdef DSP_MEM_DEFRAMER_POSTCHK_EN
                        r_err_post     <= 1'b0;
`endif
                        r_cfg_sync     <= i_cfg_syncword;
                        r_cfg_words    <= i_cfg_payload_words;
                        r_cfg_hunt_max <= i_cfg_hunt_max;
                        r_hunt_cnt     <= '0;
                        r_word_cnt     <= '0;
                        r_bit_cnt      <= '0;
                        r_word_sr      <= '0;
                    end
                end
                ST_HUNT: begin
                    if (i_bit_vld) begin
                        r_hunt_cnt <= w_hunt_cnt_inc;
                        // A match on the last counted bit wins over the timeout.
                        if (w_match) begin
                            if (r_cfg_words == '0) begin
                                r_state <= c_AFTER_PAYLOAD;
                                r_busy  <= !c_AFTER_DONE;
                                r_done  <= c_AFTER_DONE;
                            end else begin
                                r_state <= ST_PAYLOAD;
                            end
                        end else if ((r_cfg_hunt_max != '0) && (w_hunt_cnt_inc >= r_cfg_hunt_max)) begin
                            r_state    <= ST_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_err_hunt <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (i_bit_vld) begin
                        if (r_bit_cnt == c_BIT_W'(WordWidth - 1)) begin
                            r_word     <= w_word_full;
                            r_word_vld <= 1'b1;
                            r_bit_cnt  <= '0;
                            r_word_sr  <= '0;
                            r_word_cnt <= w_word_cnt_inc;
                            if (w_word_cnt_inc >= r_cfg_words) begin
                                r_state <= c_AFTER_PAYLOAD;
                                r_busy  <= !c_AFTER_DONE;
                                r_done  <= c_AFTER_DONE;
                            end
                        end else begin
                            r_word_sr <= w_word_full[WordWidth-2:0];
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_last) begin
`ifdef DSP_MEM_DEFRAMER_POSTCHK_EN
                        r_err_post <= !w_match;
`endif
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_word     = r_word;
    assign o_word_vld = r_word_vld;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err_hunt = r_err_hunt;
`ifdef DSP_MEM_DEFRAMER_POSTCHK_EN
    assign o_err_post = r_err_post;
`else
    assign o_err_post = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsp_mem_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_mem_deframer
//  Description : Self-checking bench: scenario table plus reset sequence,
//                compared against a slicing reference model of the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mem_deframer;

    localparam int c_FL = 64;
    localparam int c_WW = 32;
    localparam int c_CW = 16;
    localparam logic [63:0] c_SYNC = 64'hA5A5_F00F_1234_5678;
`ifdef DSP_MEM_DEFRAMER_POSTCHK_EN
    localparam bit c_POSTCHK = 1'b1;
`else
    localparam bit c_POSTCHK = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_bit;
    logic              i_bit_vld;
    logic              i_start;
    logic [c_FL-1:0]   i_cfg_syncword;
    logic [c_CW-1:0]   i_cfg_payload_words;
    logic [c_CW-1:0]   i_cfg_hunt_max;
    logic [c_WW-1:0]   o_word;
    logic              o_word_vld;
    logic              o_busy;
    logic              o_done;
    logic              o_err_hunt;
    logic              o_err_post;

    dsp_mem_deframer #(
        .FrameLength (c_FL),
        .WordWidth   (c_WW),
        .CountWidth  (c_CW)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_bit               (i_bit),
        .i_bit_vld           (i_bit_vld),
        .i_start             (i_start),
        .i_cfg_syncword      (i_cfg_syncword),
        .i_cfg_payload_words (i_cfg_payload_words),
        .i_cfg_hunt_max      (i_cfg_hunt_max),
        .o_word              (o_word),
        .o_word_vld          (o_word_vld),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_err_hunt          (o_err_hunt),
        .o_err_post          (o_err_post)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string             name;
        logic [63:0]       sync;
        int                nwords;
        logic [2:0][31:0]  w;
        int                hmax;
        int                njunk;
        bit                no_pre;
        bit                flip;
        int                vld_pct;
        bit                mid_start;
        bit                exp_eh;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    int          bad_strobe = 0;
    logic [31:0] got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        bit v;
        v = i_bit_vld;
        @(posedge i_clk);
        #1;
        if (o_word_vld === 1'b1) begin
            got.push_back(o_word);
            if (!v) bad_strobe++;
        end
    endtask

    task automatic drive(input bit b);
        i_bit = b;
        i_bit_vld = 1'b1;
        step();
        i_bit_vld = 1'b0;
        i_bit = 1'($urandom);
    endtask

    // Reference: find the first syncword window among the valid bits, slice words
    // after it, then compare the following window to the syncword.
    task automatic model(input bit vb[$], input logic [63:0] sync, input int nw, input int hmax,
                         output logic [31:0] ew[$], output bit eh, output bit ep, output int dat);
        int lock;
        int p;
        lock = -1;
        ew = {};
        eh = 1'b0;
        ep = 1'b0;
        dat = 0;
        for (int i = c_FL - 1; i < vb.size(); i++) begin
            logic [63:0] win;
            if (hmax != 0 && i + 1 > hmax) break;
            win = '0;
            for (int k = 0; k < c_FL; k++) win = {win[62:0], vb[i - c_FL + 1 + k]};
            if (win == sync) begin
                lock = i;
                break;
            end
        end
        if (lock < 0) begin
            if (hmax != 0 && vb.size() >= hmax) begin
                eh = 1'b1;
                dat = hmax;
            end
            return;
        end
        p = lock + 1;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] wd;
            if (p + c_WW > vb.size()) return;
            wd = '0;
            for (int k = 0; k < c_WW; k++) wd = {wd[30:0], vb[p + k]};
            ew.push_back(wd);
            p += c_WW;
        end
        if (c_POSTCHK) begin
            logic [63:0] post;
            if (p + c_FL > vb.size()) return;
            post = '0;
            for (int k = 0; k < c_FL; k++) post = {post[62:0], vb[p + k]};
            ep = (post != sync);
            p += c_FL;
        end
        dat = p;
    endtask

    task automatic start_frame(input logic [63:0] sync, input int nw, input int hmax);
        i_cfg_syncword = sync;
        i_cfg_payload_words = c_CW'(nw);
        i_cfg_hunt_max = c_CW'(hmax);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        // Configuration must have been captured at the start pulse only.
        i_cfg_syncword = {$urandom, $urandom};
        i_cfg_payload_words = c_CW'($urandom_range(1, 5));
        i_cfg_hunt_max = c_CW'(1);
    endtask

    task automatic run_frame(input vec_t v);
        bit          bits[$];
        logic [31:0] ew[$];
        bit          eh;
        bit          ep;
        int          dat;
        int          fed;
        int          done_at;
        logic [63:0] post;
        bits = {};
        for (int j = 0; j < v.njunk; j++) bits.push_back(1'($urandom));
        if (!v.no_pre) begin
            for (int k = 63; k >= 0; k--) bits.push_back(v.sync[k]);
            for (int w = 0; w < v.nwords; w++)
                for (int k = 31; k >= 0; k--) bits.push_back(v.w[w][k]);
            post = v.sync ^ {63'd0, v.flip};
            for (int k = 63; k >= 0; k--) bits.push_back(post[k]);
        end
        for (int j = 0; j < 8; j++) bits.push_back(1'($urandom));
        model(bits, v.sync, v.nwords, v.hmax, ew, eh, ep, dat);

        got = {};
        bad_strobe = 0;
        start_frame(v.sync, v.nwords, v.hmax);
        chk({v.name, " busy_after_start"}, 64'(o_busy), 64'd1);
        fed = 0;
        done_at = 0;
        foreach (bits[j]) begin
            for (int g = 0; g < 20 && $urandom_range(0, 99) >= v.vld_pct; g++) step();
            if (v.mid_start && fed == 100) i_start = 1'b1;
            drive(bits[j]);
            i_start = 1'b0;
            fed++;
            if (o_done === 1'b1 && done_at == 0) done_at = fed;
        end
        for (int j = 0; j < 4; j++) step();

        chk({v.name, " word_count"}, 64'(got.size()), 64'(ew.size()));
        foreach (ew[i]) if (i < got.size()) chk({v.name, " word"}, 64'(got[i]), 64'(ew[i]));
        chk({v.name, " done_after_bits"}, 64'(done_at), 64'(dat));
        chk({v.name, " done"}, 64'(o_done), 64'd1);
        chk({v.name, " busy_end"}, 64'(o_busy), 64'd0);
        chk({v.name, " err_hunt"}, 64'(o_err_hunt), 64'(v.exp_eh));
        chk({v.name, " err_post"}, 64'(o_err_post), 64'(v.flip && c_POSTCHK));
        chk({v.name, " strobe_on_valid"}, 64'(bad_strobe), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        vec_t rv;
        int   n_seen;
        i_rst = 1'b1;
        i_bit = 1'b0;
        i_bit_vld = 1'b0;
        i_start = 1'b0;
        i_cfg_syncword = '0;
        i_cfg_payload_words = '0;
        i_cfg_hunt_max = '0;

        //          name         sync    nw  words                                              hmax njunk nopre flip vld mid  eh
        vecs[0] = '{"basic",     c_SYNC, 3, {32'hFFFFFFFF, 32'h0, 32'hDEADBEEF},               0,   0,    0,    0,   100, 0,  0};
        vecs[1] = '{"junk37",    c_SYNC, 1, {32'h0, 32'h0, $urandom},                          0,   37,   0,    0,   100, 0,  0};
        vecs[2] = '{"hunt_to",   c_SYNC, 2, {32'h0, $urandom, $urandom},                       100, 150,  1,    0,   100, 0,  1};
        vecs[3] = '{"post_flip", c_SYNC, 3, {$urandom, $urandom, $urandom},                    0,   0,    0,    1,   100, 0,  0};
        vecs[4] = '{"vld50",     c_SYNC, 3, {32'hFFFFFFFF, 32'h0, 32'hDEADBEEF},               0,   0,    0,    0,   50,  0,  0};
        vecs[5] = '{"zero_words",c_SYNC, 0, {32'h0, 32'h0, 32'h0},                             0,   3,    0,    0,   100, 0,  0};
        vecs[6] = '{"hmax_edge", c_SYNC, 1, {32'h0, 32'h0, $urandom},                          69,  5,    0,    0,   100, 0,  0};
        vecs[7] = '{"hmax_short",c_SYNC, 1, {32'h0, 32'h0, $urandom},                          68,  5,    0,    0,   100, 0,  1};
        vecs[8] = '{"restart_ign",{$urandom, $urandom}, 3, {$urandom, $urandom, $urandom},    0,   10,   0,    0,   70,  1,  0};

        for (int j = 0; j < 3; j++) step();
        i_rst = 1'b0;
        chk("reset_outputs", 64'({o_word, o_word_vld, o_busy, o_done, o_err_hunt, o_err_post}), 64'd0);

        for (int i = 0; i < 9; i++) run_frame(vecs[i]);

        // Reset after the first of three words, with a start pulse in the same cycle.
        rv = vecs[0];
        rv.name = "after_reset";
        rv.w = {$urandom, $urandom, $urandom};
        got = {};
        start_frame(c_SYNC, 3, 0);
        for (int k = 63; k >= 0; k--) drive(c_SYNC[k]);
        for (int k = 31; k >= 0; k--) drive(rv.w[0][k]);
        for (int k = 31; k >= 22; k--) drive(rv.w[1][k]);
        chk("pre_reset_word_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("pre_reset_word", 64'(got[0]), 64'(rv.w[0]));
        i_rst = 1'b1;
        i_start = 1'b1;
        i_bit_vld = 1'b1;
        step();
        i_rst = 1'b0;
        i_start = 1'b0;
        i_bit_vld = 1'b0;
        chk("reset_midframe_outputs", 64'({o_word, o_word_vld, o_busy, o_done, o_err_hunt, o_err_post}), 64'd0);
        n_seen = got.size();
        for (int k = 21; k >= 0; k--) drive(rv.w[1][k]);
        for (int k = 31; k >= 0; k--) drive(rv.w[2][k]);
        chk("no_stale_strobe", 64'(got.size()), 64'(n_seen));
        chk("idle_after_reset", 64'({o_busy, o_done}), 64'd0);
        run_frame(rv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_mem_deframer.md
DSP_MEM_DEFRAMER -- requirements
Module: dsp_mem_deframer

Interface
REQ-001 Parameter FrameLength, default 64: syncword length in bits; equals the memory FRAME_LENGTH.
REQ-002 Parameter WordWidth, default 32: width of each assembled payload word.
REQ-003 Parameter CountWidth, default 16: width of the payload-word and hunt-timeout counters.
REQ-004 Clock and reset are decided: one clock i_clk; reset i_rst, synchronous, active-high.
REQ-005 Port i_clk, input, 1: serial read clock, the same clock that shifts the memory readout.
REQ-006 Port i_rst, input, 1: synchronous active-high reset.
REQ-007 Port i_bit, input, 1: serial data from the memory readout, MSB first.
REQ-008 Port i_bit_vld, input, 1: i_bit is sampled only in cycles where this is high.
REQ-009 Port i_start, input, 1: single-cycle pulse that arms the frame hunt.
REQ-010 Port i_cfg_syncword, input, FrameLength: expected pre/postamble word.
REQ-011 Port i_cfg_payload_words, input, CountWidth: number of payload words between the preamble and the postamble.
REQ-012 Port i_cfg_hunt_max, input, CountWidth: maximum number of valid bits to search in HUNT; 0 disables the timeout.
REQ-013 Port o_word, output, WordWidth: assembled payload word; the first received bit is the MSB.
REQ-014 Port o_word_vld, output, 1: one-cycle strobe per word; there is no backpressure.
REQ-015 Port o_busy, output, 1: high in HUNT, PAYLOAD and CHECK.
REQ-016 Port o_done, output, 1: high in DONE.
REQ-017 Port o_err_hunt, output, 1: sticky flag; HUNT timed out.
REQ-018 Port o_err_post, output, 1: sticky flag; postamble mismatch.

Function
REQ-019 FSM states shall be IDLE, HUNT, PAYLOAD, CHECK and DONE.
REQ-020 IDLE/DONE: i_start -> HUNT; clears the counters, the shift register and both error flags; i_start in any other state is ignored.
REQ-021 HUNT: each valid bit shifts into a FrameLength-bit register at the LSB; when the register including the current bit equals i_cfg_syncword, the FSM enters PAYLOAD on the next cycle.
REQ-022 Matching requires FrameLength valid bits since entry into HUNT; a register that is only partially filled never matches.
REQ-023 HUNT timeout: if i_cfg_hunt_max is nonzero and that many valid bits have been searched without a match -> DONE with o_err_hunt=1; a match on the final counted bit takes priority over the timeout.
REQ-024 PAYLOAD: valid bits assemble into WordWidth-bit words; o_word and o_word_vld update on the clock edge after the last bit of each word is sampled.
REQ-025 After word number i_cfg_payload_words is emitted -> CHECK; if i_cfg_payload_words is 0, the FSM goes from HUNT directly to CHECK.
REQ-026 CHECK: FrameLength valid bits are shifted in and compared to i_cfg_syncword; a mismatch sets o_err_post; in either case the FSM enters DONE on the next cycle.
REQ-027 Cycles with i_bit_vld low shall leave all state, counters and the partial word unchanged.
REQ-028 i_cfg_* ports are sampled only on i_start; changes at other times shall have no effect.
REQ-029 Counters shall saturate, never wrap; the payload counter width bounds the frame to 2^CountWidth-1 words.

Reset
REQ-030 When i_rst is high at a clock edge: state=IDLE; o_word=0; o_word_vld=0; o_busy=0; o_done=0; o_err_hunt=0; o_err_post=0; shift register and counters are 0.
REQ-031 Reset mid-frame shall abandon the frame without emitting a further word; i_rst takes priority over i_start in the same cycle.

Configuration
REQ-032 Macro DSP_MEM_DEFRAMER_POSTCHK_EN defined: the CHECK state and the postamble comparison are built as in REQ-026.
REQ-033 Macro DSP_MEM_DEFRAMER_POSTCHK_EN undefined: PAYLOAD goes directly to DONE, postamble bits are ignored, and o_err_post is tied to 0.

Structure
REQ-034 Package dsp_mem_deframer_pkg shall hold the state enum typedef and the default parameter constants.
REQ-035 Sub-module dsp_mem_deframer_sync_det shall implement the shift register and syncword comparator; it is instantiated once and reused by HUNT and CHECK.

Verification
REQ-036 Scenario: syncword 64'hA5A5_F00F_1234_5678, 3 words 32'hDEADBEEF/0/FFFFFFFF, postamble sent -> 3 vld strobes with those values, then o_done=1 and no errors.
REQ-037 Scenario: 37 random bits, then the preamble, then 1 word -> lock on the true preamble only and 1 correct word.
REQ-038 Scenario: hunt_max=100, no syncword in the stream -> o_done=1 and o_err_hunt=1 after exactly 100 valid bits, with no word strobes.
REQ-039 Scenario: postamble bit 0 flipped -> o_err_post=1 in DONE (macro on); o_err_post=0 (macro off).
REQ-040 Scenario: i_bit_vld toggled 50% at random, same frame as REQ-036 -> identical words, strobes only after valid bits.
REQ-041 Scenario: i_rst asserted after word 1 of 3, then i_start with a new frame -> no stale strobe, new frame decoded correctly.
